// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, key codes and helpers for the 24-game round controller
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAL    = 3'd1,
        ST_PICK_A  = 3'd2,
        ST_PICK_OP = 3'd3,
        ST_PICK_B  = 3'd4,
        ST_CALC    = 3'd5,
        ST_CHECK   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_MUL  = 4'hC;
    localparam logic [3:0] KEY_DIV  = 4'hD;
    localparam logic [3:0] KEY_BACK = 4'hE;
    localparam logic [3:0] KEY_CLR  = 4'hF;

    localparam int TARGET_DEFAULT = 24;

    // Keys A..D map onto OP_ADD..OP_DIV by offsetting the low two bits
    function automatic op_t key_to_op(input logic [3:0] k);
        return op_t'(k[1:0] + 2'd2);
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle, sync clear abort
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  q_q, q_d, r_q, r_d, d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [W:0]    rem_shift, diff;

    always_comb begin
        rem_shift = {r_q, q_q[W-1]};
        diff      = rem_shift - {1'b0, d_q};
        q_d       = q_q;
        r_d       = r_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (clr) begin
            busy_d = 1'b0;
        end else if (start && !busy_q) begin
            q_d    = dividend;
            r_d    = '0;
            d_d    = divisor;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // diff[W] set means the trial subtraction borrowed: restore
            q_d   = {q_q[W-2:0], ~diff[W]};
            r_d   = diff[W] ? rem_shift[W-1:0] : diff[W-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            r_q    <= r_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = q_q;
    assign remainder = r_q;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - 24-game round controller: deal, keypad sequencing, timer, win/lose; GAME_UNDO_EN adds one-deep undo
module game_ctrl
    import game_pkg::*;
#(
    parameter int          TIME_LIMIT = 60,
    parameter int          VAL_W      = 16,
    parameter int          TARGET     = TARGET_DEFAULT,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5,
    parameter logic [15:0] FIXED_DEAL = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic [4*VAL_W-1:0] cards,
    output logic [3:0]         card_live,
    output logic [2:0]         state,
    output logic [6:0]         time_left,
    output logic               win,
    output logic               lose,
    output logic               err
);

    localparam logic [VAL_W-1:0] TARGET_V = VAL_W'(TARGET);

    state_t                  state_q, state_d;
    op_t                     op_q, op_d;
    logic [7:0]              lfsr_q, lfsr_d;
    logic [3:0][VAL_W-1:0]   cards_q, cards_d, deal_q, deal_d;
    logic [3:0]              live_q, live_d;
    logic [6:0]              time_q, time_d;
    logic                    win_q, win_d, lose_q, lose_d, err_q, err_d;
    logic [1:0]              sel_a_q, sel_a_d, sel_b_q, sel_b_d, deal_idx_q, deal_idx_d;
    logic                    div_go_q, div_go_d;
`ifdef GAME_UNDO_EN
    logic [3:0][VAL_W-1:0]   undo_cards_q, undo_cards_d;
    logic [3:0]              undo_live_q, undo_live_d;
    logic                    undo_valid_q, undo_valid_d;
`endif

    logic [VAL_W-1:0] a_v, b_v, mag_a, mag_b, div_q, div_r, res, deal_val, live_val;
    logic             div_start, div_clr, div_busy, div_done;
    logic             in_pick, in_play, timeout, is_slot, commit;

    assign a_v     = cards_q[sel_a_q];
    assign b_v     = cards_q[sel_b_q];
    assign mag_a   = a_v[VAL_W-1] ? (~a_v + VAL_W'(1)) : a_v;
    assign mag_b   = b_v[VAL_W-1] ? (~b_v + VAL_W'(1)) : b_v;
    assign is_slot = (key_code[3:2] == 2'b00);
    assign in_pick = (state_q == ST_PICK_A) || (state_q == ST_PICK_OP) || (state_q == ST_PICK_B);
    assign in_play = in_pick || (state_q == ST_CALC);
    assign timeout = in_play && tick && (time_q == 7'd1);

    always_comb begin
        case (op_q)
            OP_ADD:  res = a_v + b_v;
            OP_SUB:  res = a_v - b_v;
            OP_MUL:  res = a_v * b_v;
            default: res = (a_v[VAL_W-1] ^ b_v[VAL_W-1]) ? (~div_q + VAL_W'(1)) : div_q;
        endcase
        if (FIXED_DEAL != 16'h0000)
            deal_val = VAL_W'(FIXED_DEAL[{deal_idx_q, 2'b00} +: 4]);
        else
            deal_val = VAL_W'(lfsr_q[3:0] % 4'd9) + VAL_W'(1);
        live_val = '0;
        for (int i = 0; i < 4; i++)
            if (live_q[i]) live_val = cards_q[i];
    end

    seq_divider #(.W(VAL_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .clr       (div_clr),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cards_d    = cards_q;
        deal_d     = deal_q;
        live_d     = live_q;
        time_d     = time_q;
        win_d      = win_q;
        lose_d     = lose_q;
        err_d      = 1'b0;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        deal_idx_d = deal_idx_q;
        div_go_d   = div_go_q;
        div_start  = 1'b0;
        div_clr    = 1'b0;
        commit     = 1'b0;
`ifdef GAME_UNDO_EN
        undo_cards_d = undo_cards_q;
        undo_live_d  = undo_live_q;
        undo_valid_d = undo_valid_q;
`endif
        if (in_play && tick) time_d = time_q - 7'd1;

        // Timeout wins over keys and CALC completion, and never pulses err
        if (timeout) begin
            lose_d  = 1'b1;
            state_d = ST_DONE;
            div_clr = 1'b1;
        end else if (in_pick && key_valid && key_code == KEY_CLR) begin
            cards_d = deal_q;
            live_d  = 4'hF;
            state_d = ST_PICK_A;
`ifdef GAME_UNDO_EN
            undo_valid_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d    = ST_DEAL;
                        win_d      = 1'b0;
                        lose_d     = 1'b0;
                        deal_idx_d = 2'd0;
                    end
                end
                ST_DEAL: begin
                    cards_d[deal_idx_q] = deal_val;
                    deal_d[deal_idx_q]  = deal_val;
                    deal_idx_d          = deal_idx_q + 2'd1;
`ifdef GAME_UNDO_EN
                    undo_valid_d = 1'b0;
`endif
                    if (deal_idx_q == 2'd3) begin
                        live_d  = 4'hF;
                        time_d  = 7'(TIME_LIMIT);
                        state_d = ST_PICK_A;
                    end
                end
                ST_PICK_A: begin
                    if (key_valid && is_slot) begin
                        if (live_q[key_code[1:0]]) begin
                            sel_a_d = key_code[1:0];
                            state_d = ST_PICK_OP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_valid && key_code == KEY_BACK) begin
`ifdef GAME_UNDO_EN
                        if (undo_valid_q) begin
                            cards_d      = undo_cards_q;
                            live_d       = undo_live_q;
                            undo_valid_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
`endif
                    end
                end
                ST_PICK_OP: begin
                    if (key_valid && key_code >= KEY_ADD && key_code <= KEY_DIV) begin
                        op_d    = key_to_op(key_code);
                        state_d = ST_PICK_B;
                    end else if (key_valid && key_code == KEY_BACK) begin
                        state_d = ST_PICK_A;
                    end
                end
                ST_PICK_B: begin
                    if (key_valid && is_slot) begin
                        if (live_q[key_code[1:0]] && key_code[1:0] != sel_a_q) begin
                            sel_b_d = key_code[1:0];
                            state_d = ST_CALC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_valid && key_code == KEY_BACK) begin
                        state_d = ST_PICK_OP;
                    end
                end
                ST_CALC: begin
                    if (op_q != OP_DIV) begin
                        commit = 1'b1;
                    end else if (!div_go_q) begin
                        if (b_v == '0) begin
                            err_d   = 1'b1;
                            state_d = ST_PICK_A;
                        end else if (!div_busy) begin
                            div_start = 1'b1;
                            div_go_d  = 1'b1;
                        end
                    end else if (div_done) begin
                        if (div_r != '0) begin
                            err_d   = 1'b1;
                            state_d = ST_PICK_A;
                        end else begin
                            commit = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    win_d   = (live_val == TARGET_V);
                    lose_d  = (live_val != TARGET_V);
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (commit) begin
`ifdef GAME_UNDO_EN
                undo_cards_d = cards_q;
                undo_live_d  = live_q;
                undo_valid_d = 1'b1;
`endif
                cards_d[sel_a_q] = res;
                cards_d[sel_b_q] = '0;
                live_d[sel_b_q]  = 1'b0;
                state_d = (popcount4(live_d) == 3'd1) ? ST_CHECK : ST_PICK_A;
            end
        end

        if (state_d != ST_CALC) div_go_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            lfsr_q     <= LFSR_SEED;
            cards_q    <= '0;
            deal_q     <= '0;
            live_q     <= '0;
            time_q     <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            err_q      <= 1'b0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            deal_idx_q <= '0;
            div_go_q   <= 1'b0;
`ifdef GAME_UNDO_EN
            undo_cards_q <= '0;
            undo_live_q  <= '0;
            undo_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lfsr_q     <= lfsr_d;
            cards_q    <= cards_d;
            deal_q     <= deal_d;
            live_q     <= live_d;
            time_q     <= time_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            err_q      <= err_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            deal_idx_q <= deal_idx_d;
            div_go_q   <= div_go_d;
`ifdef GAME_UNDO_EN
            undo_cards_q <= undo_cards_d;
            undo_live_q  <= undo_live_d;
            undo_valid_q <= undo_valid_d;
`endif
        end
    end

    assign cards     = cards_q;
    assign card_live = live_q;
    assign state     = state_q;
    assign time_left = time_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign err       = err_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl with a fixed 6,4,1,1 deal
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [63:0] cards;
    logic [3:0]  card_live;
    logic [2:0]  state;
    logic [6:0]  time_left;
    logic        win, lose, err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] DEALT = 64'h0001_0001_0004_0006;

    game_ctrl #(
        .TIME_LIMIT (3),
        .VAL_W      (16),
        .TARGET     (24),
        .LFSR_SEED  (8'hA5),
        .FIXED_DEAL (16'h1146)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tick      (tick),
        .key_valid (key_valid),
        .key_code  (key_code),
        .cards     (cards),
        .card_live (card_live),
        .state     (state),
        .time_left (time_left),
        .win       (win),
        .lose      (lose),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic new_round();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
    endtask

    task automatic finish_calc(input string tag);
        int n = 0;
        while (state == 3'd5 && n < 40) begin
            step();
            n++;
        end
        check_eq(tag, 64'(state == 3'd5), 64'd0);
    endtask

    task automatic op3(input logic [3:0] a, input logic [3:0] op, input logic [3:0] b, input string tag);
        press(a);
        press(op);
        press(b);
        finish_calc(tag);
    endtask

    initial begin
        do_reset();
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_cards", cards, 64'd0);
        check_eq("rst_live", 64'(card_live), 64'd0);
        check_eq("rst_time", 64'(time_left), 64'd0);
        check_eq("rst_flags", 64'({win, lose, err}), 64'd0);

        // Winning line: 6*4, 1*1, 24*1
        new_round();
        check_eq("deal_state", 64'(state), 64'd2);
        check_eq("deal_cards", cards, DEALT);
        check_eq("deal_live", 64'(card_live), 64'hF);
        check_eq("deal_time", 64'(time_left), 64'd3);
        op3(4'h0, 4'hC, 4'h1, "calc_mul1");
        check_eq("mul1_cards", cards, 64'h0001_0001_0000_0018);
        check_eq("mul1_live", 64'(card_live), 64'hD);
        op3(4'h2, 4'hC, 4'h3, "calc_mul2");
        op3(4'h0, 4'hC, 4'h2, "calc_mul3");
        check_eq("check_state", 64'(state), 64'd6);
        step();
        check_eq("win_state", 64'(state), 64'd7);
        check_eq("win_cards", cards, 64'h0000_0000_0000_0018);
        check_eq("win_live", 64'(card_live), 64'h1);
        check_eq("win_flags", 64'({win, lose}), 64'b10);

        // Inexact divide, then divide by zero
        do_reset();
        new_round();
        op3(4'h1, 4'hD, 4'h0, "calc_div_rem");
        check_eq("div_rem_err", 64'(err), 64'd1);
        check_eq("div_rem_state", 64'(state), 64'd2);
        check_eq("div_rem_cards", cards, DEALT);
        step();
        check_eq("err_pulse", 64'(err), 64'd0);
        op3(4'h2, 4'hB, 4'h3, "calc_sub0");
        check_eq("sub0_live", 64'(card_live), 64'h7);
        op3(4'h0, 4'hD, 4'h2, "calc_div0");
        check_eq("div0_err", 64'(err), 64'd1);
        check_eq("div0_state", 64'(state), 64'd2);
        check_eq("div0_cards", cards, 64'h0000_0000_0004_0006);

        // Signed exact divide: 1-4 = -3, then 6 / -3 = -2
        do_reset();
        new_round();
        op3(4'h2, 4'hB, 4'h1, "calc_sub_neg");
        check_eq("neg_cards", cards, 64'h0001_FFFD_0000_0006);
        op3(4'h0, 4'hD, 4'h2, "calc_div_neg");
        check_eq("divneg_err", 64'(err), 64'd0);
        check_eq("divneg_cards", cards, 64'h0001_0000_0000_FFFE);
        check_eq("divneg_live", 64'(card_live), 64'h9);

        // Negative result, then clear restores the deal
        do_reset();
        new_round();
        op3(4'h2, 4'hB, 4'h0, "calc_sub5");
        check_eq("sub5_cards", cards, 64'h0001_FFFB_0004_0000);
        check_eq("sub5_live", 64'(card_live), 64'hE);
        press(4'hF);
        check_eq("clr_state", 64'(state), 64'd2);
        check_eq("clr_cards", cards, DEALT);
        check_eq("clr_live", 64'(card_live), 64'hF);

        // Timeout with a coincident key on the final tick
        do_reset();
        new_round();
        pulse_tick();
        check_eq("tick1_time", 64'(time_left), 64'd2);
        pulse_tick();
        check_eq("tick2_time", 64'(time_left), 64'd1);
        tick = 1'b1;
        key_code = 4'h0;
        key_valid = 1'b1;
        step();
        tick = 1'b0;
        key_valid = 1'b0;
        check_eq("tmo_time", 64'(time_left), 64'd0);
        check_eq("tmo_state", 64'(state), 64'd7);
        check_eq("tmo_flags", 64'({win, lose, err}), 64'b010);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("restart_state", 64'(state), 64'd1);
        check_eq("restart_lose", 64'(lose), 64'd0);

        // Same slot for B, ignored start, then reset during a divide
        do_reset();
        new_round();
        press(4'h0);
        press(4'hC);
        press(4'h0);
        check_eq("same_slot_err", 64'(err), 64'd1);
        check_eq("same_slot_state", 64'(state), 64'd4);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start_ignored", 64'(state), 64'd4);
        press(4'hE);
        check_eq("back_state", 64'(state), 64'd3);
        press(4'hD);
        press(4'h1);
        repeat (3) step();
        check_eq("mid_div_state", 64'(state), 64'd5);
        rst = 1'b1;
        #1;
        check_eq("arst_state", 64'(state), 64'd0);
        check_eq("arst_cards", cards, 64'd0);
        check_eq("arst_misc", 64'({card_live, time_left, win, lose, err}), 64'd0);
        #2;
        rst = 1'b0;
        step();
        check_eq("post_rst_state", 64'(state), 64'd0);

        // Back key in PICK_A
        do_reset();
        new_round();
        op3(4'h0, 4'hA, 4'h1, "calc_add");
        check_eq("add_cards", cards, 64'h0001_0001_0000_000A);
`ifdef GAME_UNDO_EN
        press(4'hE);
        check_eq("undo_err", 64'(err), 64'd0);
        check_eq("undo_cards", cards, DEALT);
        check_eq("undo_live", 64'(card_live), 64'hF);
        press(4'hE);
        check_eq("undo2_err", 64'(err), 64'd1);
        check_eq("undo2_cards", cards, DEALT);
`else
        press(4'hE);
        check_eq("back_a_err", 64'(err), 64'd0);
        check_eq("back_a_state", 64'(state), 64'd2);
        check_eq("back_a_cards", cards, 64'h0001_0001_0000_000A);
        check_eq("back_a_live", 64'(card_live), 64'hD);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
